// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: request/grant fetch with multiple outstanding
// requests, a prefetch circular buffer towards Decode, and redirect handling
// that discards responses still in flight when a flush arrives.
module instruction_fetch_queue #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     QUEUE_DEPTH     = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [XLEN-1:0] jump_addr,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [XLEN-1:0] r_q_inst [QUEUE_DEPTH];
  logic [XLEN-1:0] r_q_pc   [QUEUE_DEPTH];

  logic            w_out_ok;
  logic            w_credit_ok;
  logic            w_req;
  logic            w_gnt;
  logic            w_rsp;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_jump_aligned;

  // Credit check: never request more than the queue can absorb, counting
  // in-flight requests (including ones that will be discarded).
  assign w_out_ok    = r_outstanding < CW'(MAX_OUTSTANDING);
  assign w_credit_ok = (SW'(r_outstanding) + SW'(r_count)) < SW'(QUEUE_DEPTH);
  assign w_req       = rst_n && !flush && w_out_ok && w_credit_ok;
  assign w_gnt       = w_req && mem_gnt;

  // Responses with nothing outstanding (e.g. strays after reset) are ignored.
  assign w_rsp  = mem_rvalid && (r_outstanding != '0);
  assign w_drop = w_rsp && (r_discard != '0);
  assign w_push = w_rsp && !w_drop && !flush;
  assign w_pop  = id_valid && id_ready && !flush;

  assign w_jump_aligned = {jump_addr[XLEN-1:2], 2'b00};

  assign mem_req  = w_req;
  assign mem_addr = r_fetch_pc;
  assign id_valid = (r_count != '0);
  assign id_inst  = id_valid ? r_q_inst[r_head] : '0;
  assign id_pc    = id_valid ? r_q_pc[r_head]   : '0;

  // Control state: PCs, occupancy, pointers, outstanding and discard credits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(w_rsp);
      if (flush) begin
        r_fetch_pc <= w_jump_aligned;
        r_resp_pc  <= w_jump_aligned;
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_discard  <= r_outstanding - CW'(w_rsp);
      end else begin
        if (w_gnt) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
          r_tail    <= r_tail + PW'(1);
        end
        if (w_drop) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Queue storage: written at the tail on push; contents are only visible
  // through the head when the entry is valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_tail] <= mem_rdata;
      r_q_pc[r_tail]   <= r_resp_pc;
    end
  end

  // The credit rule must prevent a push into a full queue without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == CW'(QUEUE_DEPTH)) && !w_pop));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: variable-latency memory model, a
// scoreboard of expected {pc, inst} per grant, a flush vector table and
// hand-written sequences for backpressure, reset and PC wrap.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] jump_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  // Second instance: wrap-around of the PC with a deeper queue.
  logic        flush2;
  logic [31:0] jump2;
  logic        mem_req2;
  logic [31:0] mem_addr2;
  logic        mem_gnt2;
  logic        rv2 = 1'b0;
  logic [31:0] rd2 = 32'h0;
  logic        id_valid2;
  logic        id_ready2;
  logic [31:0] id_inst2;
  logic [31:0] id_pc2;
  logic [31:0] pcs2[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .jump_addr(jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  instruction_fetch_queue #(
    .XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(8), .MAX_OUTSTANDING(2)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .jump_addr(jump2),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_gnt(mem_gnt2),
    .mem_rvalid(rv2), .mem_rdata(rd2),
    .id_valid(id_valid2), .id_ready(id_ready2), .id_inst(id_inst2), .id_pc(id_pc2)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model state and scoreboard.
  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  pend_t       pend_q[$];
  exp_t        exp_q[$];
  int unsigned lat = 1;
  int unsigned cyc = 0;

  // Main memory model + scoreboard, evaluated mid-cycle when everything is stable.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n || flush) begin
      exp_q.delete();
    end else if (id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h with no expected entry", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_inst", id_inst, e.inst);
      end
    end
    if (mem_rvalid && pend_q.size() != 0) pend_q.delete(0);
    if (mem_req && mem_gnt) begin
      pend_q.push_back('{mem_addr, cyc + lat});
      exp_q.push_back('{mem_addr, inst_of(mem_addr)});
    end
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = inst_of(pend_q[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Wrap instance memory: fixed 1-cycle latency, always granting.
  always @(posedge clk) begin
    rv2 <= mem_req2 && mem_gnt2;
    rd2 <= inst_of(mem_addr2);
  end

  always @(negedge clk) begin
    if (rst_n && id_valid2 && id_ready2 && pcs2.size() < 3) pcs2.push_back(id_pc2);
  end

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!id_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", id_valid, 1);
  endtask

  typedef struct { logic [31:0] jump; int unsigned lt; logic [31:0] exp_pc; } vec_t;
  vec_t vt[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nvalid;
    int nstray;

    vt[0] = '{32'h0000_0100, 3, 32'h0000_0100};
    vt[1] = '{32'h0000_0103, 1, 32'h0000_0100};
    vt[2] = '{32'h0000_02FE, 2, 32'h0000_02FC};
    vt[3] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC};

    rst_n = 1'b0; flush = 1'b0; jump_addr = 32'h0; mem_gnt = 1'b0; id_ready = 1'b0;
    flush2 = 1'b0; jump2 = 32'h0; mem_gnt2 = 1'b1; id_ready2 = 1'b1;
    lat = 1;

    // Reset values.
    #2;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_inst", id_inst, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // Streaming with 1-cycle memory and Decode always ready.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; mem_gnt = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stream_addr", mem_addr, 32'(4 * i));
      chk("stream_valid", id_valid, (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) chk("stream_pc", id_pc, 32'(4 * (i - 2)));
    end

    // Wrap-around instance.
    if (pcs2.size() >= 3) begin
      chk("wrap_pc0", pcs2[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", pcs2[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", pcs2[2], 32'h0000_0000);
    end else begin
      checks++;
      errors++;
      $display("FAIL wrap_count: got %0d pops expected 3", pcs2.size());
    end

    // Backpressure: redirect to 0 with Decode stalled, queue must fill to 4.
    @(posedge clk); #1 id_ready = 1'b0; flush = 1'b1; jump_addr = 32'h0;
    @(posedge clk); #1 flush = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_req_low", mem_req, 0);
    chk("bp_valid", id_valid, 1);
    chk("bp_head_pc", id_pc, 32'h0);
    chk("bp_head_inst", id_inst, inst_of(32'h0));
    @(posedge clk); #1 mem_gnt = 1'b0; id_ready = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(id_valid);
    end
    chk("bp_drain_count", n, 4);
    @(posedge clk); #1 mem_gnt = 1'b1;

    // Flush vectors.
    for (int v = 0; v < 4; v++) begin
      lat = vt[v].lt;
      repeat (8) @(posedge clk);
      #1 flush = 1'b1; jump_addr = vt[v].jump;
      @(negedge clk);
      chk("flush_req_low", mem_req, 0);
      if (vt[v].lt == 1) chk("flush_head_valid", id_valid, 1);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_empty", id_valid, 0);
      chk("flush_fetch_addr", mem_addr, vt[v].exp_pc);
      wait_valid(30);
      chk("flush_first_pc", id_pc, vt[v].exp_pc);
      chk("flush_first_inst", id_inst, inst_of(vt[v].exp_pc));
    end

    // Reset with requests in flight; their responses must be ignored.
    lat = 4;
    repeat (8) @(posedge clk);
    n = 0;
    @(negedge clk);
    while (!(mem_req && mem_gnt) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 mem_gnt = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid_rst_id_valid", id_valid, 0);
    chk("mid_rst_id_inst", id_inst, 0);
    chk("mid_rst_id_pc", id_pc, 0);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    nvalid = 0;
    nstray = 0;
    repeat (8) begin
      @(posedge clk); #1;
      nvalid += int'(id_valid);
      nstray += int'(mem_rvalid);
    end
    chk("stray_no_push", nvalid, 0);
    chk("stray_seen", (nstray != 0) ? 32'd1 : 32'd0, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    wait_valid(30);
    chk("restart_pc", id_pc, 32'h0);
    chk("restart_inst", id_inst, inst_of(32'h0));
    repeat (6) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Parametrised successor to the single-register fetch stage. It decouples instruction fetch from decode with a prefetch queue and a request/grant memory interface that tolerates variable latency and multiple outstanding requests. It sits between the instruction memory and the Decode stage. It also handles redirects (branch/jump flush) while fetches are still in flight.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, PC fetched first after reset
QUEUE_DEPTH, 4, prefetch queue entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max granted-but-unanswered memory requests (1..QUEUE_DEPTH)

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous reset, active low
flush  in  1  redirect fetch to jump_addr; discard queue and in-flight fetches
jump_addr  in  XLEN  redirect target
mem_req  out  1  fetch request valid
mem_addr  out  XLEN  fetch address (word aligned)
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  response valid (in request order, >=1 cycle after grant)
mem_rdata  in  XLEN  instruction word of response
id_valid  out  1  queue head valid for Decode
id_ready  in  1  Decode accepts head this cycle
id_inst  out  XLEN  head instruction
id_pc  out  XLEN  PC of head instruction

Behaviour:
- Single clock domain. All state resets asynchronously on rst_n low.
- Reset values: fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, discard=0. Outputs: id_valid=0, id_inst=0, id_pc=0, mem_req=0, mem_addr=RESET_PC.
- Request issue:
  - mem_req = !flush && (outstanding < MAX_OUTSTANDING) && (outstanding + count < QUEUE_DEPTH). Requests due to be discarded count in outstanding.
  - mem_addr = fetch_pc.
  - A request is accepted when mem_req && mem_gnt in the same cycle. Then fetch_pc += 4 and outstanding += 1.
  - The block may drop mem_req without a grant. The memory has no hold requirement.
- Response:
  - On mem_rvalid, outstanding -= 1 (net with a simultaneous grant).
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise: push {resp_pc, mem_rdata} and resp_pc += 4.
- Queue behaviour:
  - Circular buffer with registered storage.
  - id_valid = count != 0. id_inst/id_pc come from the head entry.
  - Pop when id_valid && id_ready. Push and pop in the same cycle are allowed at any occupancy, including full.
  - The credit rule guarantees a push never hits a full queue without a pop. Assertion: no push while full and not popping.
  - Head contents are stable while id_valid && !id_ready.
- Flush (highest priority):
  - Same cycle: mem_req=0, no pop.
  - Next edge: queue cleared (count=0, pointers reset), fetch_pc=resp_pc={jump_addr[XLEN-1:2],2'b00}.
  - discard = outstanding minus 1 if mem_rvalid in the flush cycle (a response arriving in the flush cycle is itself dropped).
  - Issue to the new target may start the cycle after flush, while discards are still pending.
  - Back-to-back flushes: the last one wins; discard is recomputed each time.
- Latency: first id_valid no earlier than 2 cycles after grant (grant cycle, >=1 cycle memory, registered push). Throughput is 1 instr/cycle with memory latency 1 and MAX_OUTSTANDING>=2.
- Arithmetic: PC increments modulo 2^XLEN (wrap from 0xFFFF_FFFC to 0). Counter widths are $clog2(QUEUE_DEPTH+1).
- Reset mid-operation: all in-flight state is lost. Responses arriving after rst_n deasserts with outstanding=0 are ignored (no push, no underflow).

Test Plan:
- Reset, memory grants always with 1-cycle latency, id_ready=1 -> mem_addr 0,4,8..., id_pc 0,4,8 on consecutive cycles from the cycle after the first rvalid, id_inst matches memory.
- id_ready=0 for 10 cycles -> exactly 4 entries queued, mem_req drops once outstanding+count=4, head holds PC 0. Release -> in-order drain, no loss or duplicate.
- Memory latency 3, 2 requests outstanding, flush to jump_addr=0x100 -> both old responses dropped, next id_pc=0x100, id_inst=mem[0x100].
- Flush with jump_addr=0x103 in the same cycle as an rvalid and an id_ready pop -> response dropped, queue empty next cycle, next fetch address 0x100.
- RESET_PC=0xFFFF_FFF8, QUEUE_DEPTH=8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n asserted while 2 requests are outstanding -> all outputs return to reset values immediately. Stray rvalid after release causes no push and id_valid stays 0.
